// File: rtl/mp_arith_pkg.sv
// rtl/mp_arith_pkg.sv - shared FSM states and sizing helpers for the multi-precision adder
package mp_arith_pkg;

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        CALC = 4'b0010,
        RED  = 4'b0100,
        FIN  = 4'b1000
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int nchunk(input int width, input int chunk);
        return (width + chunk - 1) / chunk;
    endfunction

endpackage

// File: rtl/mp_addsub_seq_if.sv
// rtl/mp_addsub_seq_if.sv - operand/result handshake bundle; in_m only with MP_ADDSUB_MODRED_EN
interface mp_addsub_seq_if #(
    parameter int WIDTH = 513
);
    logic             start;
    logic             subtract;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
`ifdef MP_ADDSUB_MODRED_EN
    logic [WIDTH-1:0] in_m;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH:0]   result;

`ifdef MP_ADDSUB_MODRED_EN
    modport master (output start, subtract, in_a, in_b, in_m, input busy, done, result);
    modport slave  (input start, subtract, in_a, in_b, in_m, output busy, done, result);
`else
    modport master (output start, subtract, in_a, in_b, input busy, done, result);
    modport slave  (input start, subtract, in_a, in_b, output busy, done, result);
`endif
endinterface

// File: rtl/mp_addsub_slice.sv
// rtl/mp_addsub_slice.sv - combinational CHUNK-bit add/subtract slice with carry in/out
module mp_addsub_slice #(
    parameter int CHUNK = 171
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             inv_b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);
    logic [CHUNK-1:0] b_eff;
    logic [CHUNK:0]   s;

    assign b_eff = inv_b ? ~b : b;
    assign s     = {1'b0, a} + {1'b0, b_eff} + {{CHUNK{1'b0}}, cin};
    assign sum   = s[CHUNK-1:0];
    assign cout  = s[CHUNK];
endmodule

// File: rtl/mp_addsub_seq.sv
// rtl/mp_addsub_seq.sv - sequential multi-precision add/sub, one CHUNK slice per cycle
// MP_ADDSUB_MODRED_EN adds a RED pass applying modular correction against in_m.
module mp_addsub_seq
    import mp_arith_pkg::*;
#(
    parameter int WIDTH = 513,
    parameter int CHUNK = 171
) (
    input  logic          clk,
    input  logic          resetn,
    mp_addsub_seq_if.slave bus
);
    localparam int NCHUNK  = nchunk(WIDTH, CHUNK);
    localparam int PW      = NCHUNK * CHUNK;
    localparam int CW      = (clog2(NCHUNK) < 1) ? 1 : clog2(NCHUNK);
    localparam bit PAD     = (PW != WIDTH);
    localparam int TOP_BIT = PAD ? (WIDTH - (NCHUNK - 1) * CHUNK) : 0;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            sub_q;
    logic            carry_q;
    logic [PW-1:0]   a_q;
    logic [PW-1:0]   b_q;
    logic [PW-1:0]   r_q;
    logic            busy_q;
    logic            done_q;
    logic [WIDTH:0]  res_q;
`ifdef MP_ADDSUB_MODRED_EN
    localparam logic [PW-1:0] WMASK = ~({PW{1'b1}} << WIDTH);
    logic [PW-1:0]   m_q;
    logic            rc_q;
    logic [PW-1:0]   ins_a;
    logic [PW-1:0]   rot_r;
    logic            use_corr;
`endif

    logic [CHUNK-1:0] sl_x;
    logic [CHUNK-1:0] sl_y;
    logic             sl_inv;
    logic             sl_cin;
    logic [CHUNK-1:0] sl_sum;
    logic             sl_cout;
    logic             carry_w;
    logic [PW-1:0]    ins_r;

    // CALC feeds a/b; RED feeds the uncorrected r against m with the opposite operation
    always_comb begin
        sl_x   = a_q[CHUNK-1:0];
        sl_y   = b_q[CHUNK-1:0];
        sl_inv = sub_q;
`ifdef MP_ADDSUB_MODRED_EN
        if (state == RED) begin
            sl_x   = r_q[CHUNK-1:0];
            sl_y   = m_q[CHUNK-1:0];
            sl_inv = ~sub_q;
        end
`endif
        sl_cin = (cnt == '0) ? sl_inv : carry_q;
    end

    mp_addsub_slice #(.CHUNK(CHUNK)) u_slice (
        .a     (sl_x),
        .b     (sl_y),
        .inv_b (sl_inv),
        .cin   (sl_cin),
        .sum   (sl_sum),
        .cout  (sl_cout)
    );

    // With complemented padding the carry ripples through to cout; otherwise it lands at bit WIDTH
    assign carry_w = (sl_inv || !PAD) ? sl_cout : sl_sum[TOP_BIT];
    assign ins_r   = (PW'(sl_sum) << (PW - CHUNK)) | (r_q >> CHUNK);
`ifdef MP_ADDSUB_MODRED_EN
    assign ins_a    = (PW'(sl_sum) << (PW - CHUNK)) | (a_q >> CHUNK);
    assign rot_r    = (PW'(r_q[CHUNK-1:0]) << (PW - CHUNK)) | (r_q >> CHUNK);
    assign use_corr = sub_q ? ~rc_q : (rc_q | carry_w);
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            cnt     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
`ifdef MP_ADDSUB_MODRED_EN
            m_q     <= '0;
            rc_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE, FIN: begin
                    if (bus.start) begin
                        a_q     <= PW'(bus.in_a);
                        b_q     <= PW'(bus.in_b);
`ifdef MP_ADDSUB_MODRED_EN
                        m_q     <= PW'(bus.in_m);
`endif
                        sub_q   <= bus.subtract;
                        cnt     <= '0;
                        carry_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state   <= CALC;
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    a_q     <= a_q >> CHUNK;
                    b_q     <= b_q >> CHUNK;
                    carry_q <= sl_cout;
                    if (cnt == LAST) begin
                        cnt <= '0;
`ifdef MP_ADDSUB_MODRED_EN
                        r_q   <= ins_r & WMASK;
                        rc_q  <= carry_w;
                        state <= RED;
`else
                        r_q    <= ins_r;
                        res_q  <= {carry_w, ins_r[WIDTH-1:0]};
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= FIN;
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                        r_q <= ins_r;
                    end
                end
`ifdef MP_ADDSUB_MODRED_EN
                RED: begin
                    // a_q collects the corrected value while r_q rotates back to its original order
                    a_q     <= ins_a;
                    m_q     <= m_q >> CHUNK;
                    r_q     <= rot_r;
                    carry_q <= sl_cout;
                    if (cnt == LAST) begin
                        cnt    <= '0;
                        res_q  <= {1'b0, use_corr ? ins_a[WIDTH-1:0] : rot_r[WIDTH-1:0]};
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= FIN;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`endif
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = res_q;

endmodule

// File: tb/tb_mp_addsub_seq.sv
// tb/tb_mp_addsub_seq.sv - scoreboard bench for mp_addsub_seq (both MP_ADDSUB_MODRED_EN builds)
module tb_mp_addsub_seq;
    localparam int WS = 8;
    localparam int WD = 513;
    localparam int CD = 171;
`ifdef MP_ADDSUB_MODRED_EN
    localparam int CS    = 4;
    localparam int LAT_S = 5;
    localparam int LAT_D = 7;
`else
    localparam int CS    = 3;
    localparam int LAT_S = 4;
    localparam int LAT_D = 4;
`endif
    localparam logic [7:0] M_S = 8'hF1;

    typedef logic [513:0] v_t;
    typedef struct {
        v_t res;
        int due;
    } exp_t;

    exp_t q_s[$];
    exp_t q_d[$];
    exp_t e_s;
    exp_t e_d;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    mp_addsub_seq_if #(.WIDTH(WS)) s_if ();
    mp_addsub_seq_if #(.WIDTH(WD)) d_if ();

    mp_addsub_seq #(.WIDTH(WS), .CHUNK(CS)) dut_s (.clk(clk), .resetn(resetn), .bus(s_if.slave));
    mp_addsub_seq #(.WIDTH(WD), .CHUNK(CD)) dut_d (.clk(clk), .resetn(resetn), .bus(d_if.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input v_t got, input v_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic v_t ref_op(input logic [512:0] a, input logic [512:0] b,
                                  input logic [512:0] m, input bit sub, input int w);
        logic [514:0] mask, aa, bb, mm, r;
        mask = (515'(1) << w) - 515'(1);
        aa = 515'(a) & mask;
        bb = 515'(b) & mask;
        mm = 515'(m) & mask;
        if (!sub) begin
            r = aa + bb;
        end else begin
            r = (aa - bb) & mask;
            r[w] = (aa >= bb);
        end
`ifdef MP_ADDSUB_MODRED_EN
        if (!sub) begin
            if (r >= mm) r = r - mm;
        end else if (aa < bb) begin
            r = r + mm;
        end
        r = r & mask;
`endif
        return r[513:0];
    endfunction

    function automatic logic [512:0] rnd513();
        logic [543:0] t;
        for (int i = 0; i < 17; i++) t[i*32 +: 32] = $urandom;
        return t[512:0];
    endfunction

    always @(negedge clk) begin
        if (s_if.done === 1'b1) begin
            if (q_s.size() == 0) begin
                check_eq("s_spurious_done", v_t'(s_if.done), v_t'(0));
            end else begin
                e_s = q_s.pop_front();
                check_eq("s_result", v_t'(s_if.result), e_s.res);
                check_eq("s_latency", v_t'(cyc), v_t'(e_s.due));
            end
        end
        if (d_if.done === 1'b1) begin
            if (q_d.size() == 0) begin
                check_eq("d_spurious_done", v_t'(d_if.done), v_t'(0));
            end else begin
                e_d = q_d.pop_front();
                check_eq("d_result", v_t'(d_if.result), e_d.res);
                check_eq("d_latency", v_t'(cyc), v_t'(e_d.due));
            end
        end
    end

    task automatic wait_s_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            seen = s_if.done;
        end
        check_eq(tag, v_t'(seen), v_t'(1));
    endtask

    task automatic run_s(input logic [7:0] a, input logic [7:0] b, input bit sub, input logic [8:0] exp);
        @(negedge clk);
        s_if.start = 1'b1;
        s_if.in_a = a;
        s_if.in_b = b;
        s_if.subtract = sub;
`ifdef MP_ADDSUB_MODRED_EN
        s_if.in_m = M_S;
`endif
        q_s.push_back('{res: v_t'(exp), due: cyc + LAT_S});
        @(negedge clk);
        s_if.start = 1'b0;
        check_eq("s_busy", v_t'(s_if.busy), v_t'(1));
        wait_s_done("s_done_seen");
    endtask

    task automatic run_d(input logic [512:0] a, input logic [512:0] b, input logic [512:0] m,
                         input bit sub, input v_t exp);
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        d_if.start = 1'b1;
        d_if.in_a = a;
        d_if.in_b = b;
        d_if.subtract = sub;
`ifdef MP_ADDSUB_MODRED_EN
        d_if.in_m = m;
`endif
        q_d.push_back('{res: exp, due: cyc + LAT_D});
        @(negedge clk);
        d_if.start = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            seen = d_if.done;
        end
        check_eq("d_done_seen", v_t'(seen), v_t'(1));
    endtask

    initial begin
        logic [512:0] a, b, m;
        s_if.start = 1'b0; s_if.subtract = 1'b0; s_if.in_a = '0; s_if.in_b = '0;
        d_if.start = 1'b0; d_if.subtract = 1'b0; d_if.in_a = '0; d_if.in_b = '0;
`ifdef MP_ADDSUB_MODRED_EN
        s_if.in_m = M_S;
        d_if.in_m = '0;
`endif
        m = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_s_busy", v_t'(s_if.busy), v_t'(0));
        check_eq("rst_s_done", v_t'(s_if.done), v_t'(0));
        check_eq("rst_s_result", v_t'(s_if.result), v_t'(0));
        check_eq("rst_d_busy", v_t'(d_if.busy), v_t'(0));
        check_eq("rst_d_result", v_t'(d_if.result), v_t'(0));
        resetn = 1'b1;

`ifdef MP_ADDSUB_MODRED_EN
        run_s(8'hF0, 8'h05, 1'b0, 9'h004);
        run_s(8'h03, 8'h05, 1'b1, 9'h0EF);
        run_s(8'h10, 8'h20, 1'b0, 9'h030);
        run_s(8'hF0, 8'hF0, 1'b0, 9'h0EF);
        run_s(8'h44, 8'h44, 1'b1, 9'h000);
`else
        run_s(8'hFF, 8'h01, 1'b0, 9'h100);
        run_s(8'h05, 8'h07, 1'b1, 9'h0FE);
        run_s(8'h07, 8'h05, 1'b1, 9'h102);
        run_s(8'hFF, 8'hFF, 1'b0, 9'h1FE);
        run_s(8'h80, 8'h80, 1'b1, 9'h100);
        run_s(8'h00, 8'hFF, 1'b1, 9'h001);
`endif

        // start held high: inputs change while busy, second op taken on the done cycle
        @(negedge clk);
        s_if.start = 1'b1; s_if.in_a = 8'h3C; s_if.in_b = 8'h5A; s_if.subtract = 1'b0;
        q_s.push_back('{res: ref_op(513'(8'h3C), 513'(8'h5A), 513'(M_S), 1'b0, WS), due: cyc + LAT_S});
        q_s.push_back('{res: ref_op(513'(8'h77), 513'(8'h21), 513'(M_S), 1'b1, WS), due: cyc + 2 * LAT_S});
        @(negedge clk);
        s_if.in_a = 8'h77; s_if.in_b = 8'h21; s_if.subtract = 1'b1;
        wait_s_done("s_hold_done1");
        @(negedge clk);
        s_if.start = 1'b0;
        wait_s_done("s_hold_done2");

`ifndef MP_ADDSUB_MODRED_EN
        run_d({513{1'b1}}, {513{1'b1}}, m, 1'b0, {1'b1, {512{1'b1}}, 1'b0});
        a = rnd513();
        run_d(a, a, m, 1'b1, {1'b1, 513'd0});
        run_d('0, 513'd1, m, 1'b1, {1'b0, {513{1'b1}}});
`endif
        for (int i = 0; i < 1000; i++) begin
`ifdef MP_ADDSUB_MODRED_EN
            m = rnd513() | {1'b1, 512'd0};
            a = rnd513() % m;
            b = (i % 16 == 0) ? a : rnd513() % m;
`else
            a = rnd513();
            b = (i % 16 == 0) ? a : rnd513();
`endif
            run_d(a, b, m, 1'b0, ref_op(a, b, m, 1'b0, WD));
            run_d(a, b, m, 1'b1, ref_op(a, b, m, 1'b1, WD));
        end

        // reset during the second slice aborts the op with no done
        @(negedge clk);
        s_if.start = 1'b1; s_if.in_a = 8'h12; s_if.in_b = 8'h34; s_if.subtract = 1'b0;
        @(negedge clk);
        s_if.start = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check_eq("abort_busy", v_t'(s_if.busy), v_t'(0));
        check_eq("abort_done", v_t'(s_if.done), v_t'(0));
        check_eq("abort_result", v_t'(s_if.result), v_t'(0));
        resetn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq("abort_no_done", v_t'(s_if.done), v_t'(0));
        end

        check_eq("q_s_empty", v_t'(q_s.size()), v_t'(0));
        check_eq("q_d_empty", v_t'(q_d.size()), v_t'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
